// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU-side MMIO write path.
//   mmio_req_t    : one queued MMIO write {addr, data}
//   wq_state_t    : control states of the write queue
//   MMIO_WQ_DEPTH : default write-queue depth
package mmu_pkg;

    localparam int MMIO_WQ_DEPTH = 8;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } mmio_req_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        FLUSHING = 2'd2
    } wq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO with synchronous flush.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : discard all entries (wins over push and pop)
//   push, wdata    : enqueue request and payload
//   pop            : dequeue request (ignored when empty)
//   rdata          : head entry, read from storage registers
//   full, empty    : occupancy flags
//   count          : number of entries held
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Pointers carry a wrap bit above the index: equal pointers mean empty,
    // equal index with differing wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop && !empty;
    // A full queue still accepts a push when a slot frees in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mmio_wr_queue.sv
// MMIO write queue: turns a level-held upstream write enable into discrete
// write events, buffers them and drains them one at a time to the host port
// over valid/ready. Writes arriving at a full queue are dropped and counted.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   mmio_wr_en/addr/data         : upstream write (level enable, payload in place)
//   flush                        : discard queue, clear overflow and drop count
//   host_mmio_ready              : host accepts the presented request
//   host_mmio_valid/addr/data    : head-of-queue request
//   wq_count, wq_full            : occupancy
//   overflow, drop_cnt           : sticky drop flag, saturating drop counter
//
// state    | meaning
// IDLE     | queue empty, nothing presented to host
// DRAIN    | queue holds entries, presenting head to host
// FLUSHING | one cycle after a flush; pushes are accepted normally
module mmio_wr_queue
    import mmu_pkg::*;
#(
    parameter int DEPTH     = MMIO_WQ_DEPTH,
    parameter int EDGE_MODE = 1,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mmio_wr_en,
    input  logic [63:0]                mmio_wr_addr,
    input  logic [31:0]                mmio_wr_data,
    input  logic                       flush,
    input  logic                       host_mmio_ready,
    output logic                       host_mmio_valid,
    output logic [63:0]                host_mmio_addr,
    output logic [31:0]                host_mmio_data,
    output logic [$clog2(DEPTH):0]     wq_count,
    output logic                       wq_full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic             prev_en_q, prev_en_d;
    logic [63:0]      prev_addr_q, prev_addr_d;
    logic [31:0]      prev_data_q, prev_data_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    wq_state_t        state_q, state_d;

    logic             changed;
    logic             push_req;
    logic             pop;
    logic             drop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [AW:0]      fifo_count;
    mmio_req_t        wr_req;
    mmio_req_t        head_req;

    // A held enable re-enqueues only when the payload moves underneath it.
    assign changed  = !prev_en_q || (mmio_wr_addr != prev_addr_q) ||
                      (mmio_wr_data != prev_data_q);
    assign push_req = (EDGE_MODE != 0) ? (mmio_wr_en && changed) : mmio_wr_en;

    assign wr_req.addr = mmio_wr_addr;
    assign wr_req.data = mmio_wr_data;

    assign host_mmio_valid = !fifo_empty;
    assign pop             = host_mmio_valid && host_mmio_ready;
    assign drop            = push_req && fifo_full && !pop && !flush;

    sync_fifo #(
        .WIDTH ($bits(mmio_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_req),
        .pop   (pop),
        .wdata (wr_req),
        .rdata (head_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign host_mmio_addr = head_req.addr;
    assign host_mmio_data = head_req.data;
    assign wq_count       = fifo_count;
    assign wq_full        = fifo_full;
    assign overflow       = overflow_q;
    assign drop_cnt       = drop_cnt_q;

    always_comb begin
        prev_en_d   = mmio_wr_en;
        prev_addr_d = mmio_wr_addr;
        prev_data_d = mmio_wr_data;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        if (flush) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (fifo_count == (AW+1)'(1)) && !push_req) begin
                    state_d = IDLE;
                end
            end
            FLUSHING: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = FLUSHING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_en_q   <= 1'b0;
            prev_addr_q <= '0;
            prev_data_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            state_q     <= IDLE;
        end else begin
            prev_en_q   <= prev_en_d;
            prev_addr_q <= prev_addr_d;
            prev_data_q <= prev_data_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_mmio_wr_queue.sv
module tb_mmio_wr_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mmio_wr_en = 1'b0;
    logic [63:0] mmio_wr_addr = '0;
    logic [31:0] mmio_wr_data = '0;
    logic        flush = 1'b0;
    logic        host_mmio_ready = 1'b0;
    logic        host_mmio_valid;
    logic [63:0] host_mmio_addr;
    logic [31:0] host_mmio_data;
    logic [3:0]  wq_count;
    logic        wq_full;
    logic        overflow;
    logic [15:0] drop_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [95:0] exp_q [$];
    logic [3:0]  peak;
    logic        last_valid_neg;

    mmio_wr_queue #(
        .DEPTH     (8),
        .EDGE_MODE (1),
        .CNT_W     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mmio_wr_en      (mmio_wr_en),
        .mmio_wr_addr    (mmio_wr_addr),
        .mmio_wr_data    (mmio_wr_data),
        .flush           (flush),
        .host_mmio_ready (host_mmio_ready),
        .host_mmio_valid (host_mmio_valid),
        .host_mmio_addr  (host_mmio_addr),
        .host_mmio_data  (host_mmio_data),
        .wq_count        (wq_count),
        .wq_full         (wq_full),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: a handshake seen at the falling edge completes at the next
    // rising edge; compare it against the oldest expected request.
    always @(negedge clk) begin
        if (!rst && !flush && host_mmio_valid && host_mmio_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL host_req: got addr=%h data=%h, required no request",
                         host_mmio_addr, host_mmio_data);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                if ({host_mmio_addr, host_mmio_data} !== e) begin
                    n_fail++;
                    $display("FAIL host_req: got addr=%h data=%h, required addr=%h data=%h",
                             host_mmio_addr, host_mmio_data, e[95:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drive one cycle of upstream stimulus; returns 1 time unit after the
    // rising edge that consumed it.
    task automatic step(input logic en, input logic [63:0] a, input logic [31:0] d,
                        input bit exp);
        mmio_wr_en   = en;
        mmio_wr_addr = a;
        mmio_wr_data = d;
        if (exp) exp_q.push_back({a, d});
        @(negedge clk);
        last_valid_neg = host_mmio_valid;
        if (wq_count > peak) peak = wq_count;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", 96'(host_mmio_valid), 96'd0);
        chk("rst_payload", {host_mmio_addr, host_mmio_data}, 96'd0);
        chk("rst_count", 96'(wq_count), 96'd0);
        chk("rst_status", {79'd0, wq_full, overflow, drop_cnt}, 96'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Held enable with constant payload: one request only.
        host_mmio_ready = 1'b1;
        peak = '0;
        for (int i = 0; i < 20; i++) step(1'b1, 64'h0001_0004, 32'h41, i == 0);
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0001_0004, 32'h41, 1'b0);
        chk("hold_peak", 96'(peak), 96'd1);
        chk("hold_drained", 96'(exp_q.size()), 96'd0);

        // Data changing under a held enable: three ordered requests.
        step(1'b1, 64'h0001_0004, 32'h41, 1'b1);
        chk("no_bypass", 96'(last_valid_neg), 96'd0);
        chk("latency_valid", 96'(host_mmio_valid), 96'd1);
        step(1'b1, 64'h0001_0004, 32'h42, 1'b1);
        step(1'b1, 64'h0001_0004, 32'h43, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 32'h0, 1'b0);
        chk("chg_drained", 96'(exp_q.size()), 96'd0);
        chk("chg_count", 96'(wq_count), 96'd0);

        // Overflow: 10 pushes into 8 slots with host stalled.
        host_mmio_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            step(1'b1, 64'h2000 + 64'(4 * i), 32'h100 + 32'(i), i < 8);
        chk("ovf_full", 96'(wq_full), 96'd1);
        chk("ovf_count", 96'(wq_count), 96'd8);
        chk("ovf_drop_cnt", 96'(drop_cnt), 96'd2);
        chk("ovf_flag", 96'(overflow), 96'd1);
        host_mmio_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 32'h0, 1'b0);
        chk("ovf_drained", 96'(exp_q.size()), 96'd0);
        chk("ovf_count0", 96'(wq_count), 96'd0);
        chk("ovf_sticky", 96'(overflow), 96'd1);

        // Full queue with simultaneous push and pop.
        host_mmio_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            step(1'b1, 64'h3000 + 64'(4 * i), 32'h200 + 32'(i), 1'b1);
        chk("full_before", 96'(wq_full), 96'd1);
        host_mmio_ready = 1'b1;
        step(1'b1, 64'h3100, 32'h2ff, 1'b1);
        host_mmio_ready = 1'b0;
        chk("pp_count", 96'(wq_count), 96'd8);
        chk("pp_drop_cnt", 96'(drop_cnt), 96'd2);
        host_mmio_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 32'h0, 1'b0);
        chk("pp_drained", 96'(exp_q.size()), 96'd0);

        // Flush with a same-cycle push, then a push during FLUSHING.
        host_mmio_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h5000 + 64'(4 * i), 32'h300 + 32'(i), 1'b1);
        chk("pre_flush_count", 96'(wq_count), 96'd3);
        flush = 1'b1;
        exp_q.delete();
        step(1'b1, 64'h5100, 32'h3ff, 1'b0);
        flush = 1'b0;
        chk("flush_count", 96'(wq_count), 96'd0);
        chk("flush_valid", 96'(host_mmio_valid), 96'd0);
        chk("flush_status", {79'd0, overflow, drop_cnt}, 96'd0);
        step(1'b1, 64'h5200, 32'h377, 1'b1);
        chk("flushing_push_count", 96'(wq_count), 96'd1);
        chk("flushing_push_head", {host_mmio_addr, host_mmio_data}, {64'h5200, 32'h377});

        // Reset mid-transfer (valid=1, ready=0).
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 96'(host_mmio_valid), 96'd0);
        chk("mid_rst_payload", {host_mmio_addr, host_mmio_data}, 96'd0);
        chk("mid_rst_count", 96'(wq_count), 96'd0);
        exp_q.delete();
        mmio_wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 64'h0, 32'h0, 1'b0);
        step(1'b1, 64'h6000, 32'h55, 1'b1);
        chk("post_rst_valid", 96'(host_mmio_valid), 96'd1);
        chk("post_rst_head", {host_mmio_addr, host_mmio_data}, {64'h6000, 32'h55});

        // Streaming across pointer wrap.
        host_mmio_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            step(1'b1, 64'h6100 + 64'(4 * i), 32'h600 + 32'(i), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 32'h0, 1'b0);
        chk("wrap_drained", 96'(exp_q.size()), 96'd0);
        chk("wrap_count", 96'(wq_count), 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
